// File: rtl/data_sram_resp_pkg.sv
// Shared types and defaults for the data SRAM response model.
// Optional random response delay is enabled by DATA_SRAM_RAND_DELAY_EN.
package data_sram_resp_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DELAY  = 2;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CD_W       = 5;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] rdata;
  } resp_entry_t;

  // Fibonacci feedback for taps 16,14,13,11
  function automatic logic lfsr_fb(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

endpackage

// File: rtl/data_sram_resp_fifo.sv
// In-order queue of pending responses; head entry is visible without a pop.
module data_sram_resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  resp_entry_t              din,
  output resp_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  resp_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Payload storage needs no reset; validity lives in the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/data_sram_resp.sv
// Word-addressed data SRAM with pipelined, in-order, delayed responses.
// Define DATA_SRAM_RAND_DELAY_EN to add an LFSR-driven 0..3 cycle jitter to each response.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DELAY  = DEF_DELAY,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]       mem [WORDS];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  resp_entry_t       din;
  resp_entry_t       head;
  logic [CD_W-1:0]   cd;
  logic [CD_W-1:0]   cd_load_val;
  logic              cd_load;

  assign idx    = addr[ADDR_W+1:2];
  assign accept = req & addr_ok;

  // Byte-lane writes in the acceptance cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign din.wr    = wr;
  assign din.rdata = wr ? 32'h0 : mem[idx];

  data_sram_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .din    (din),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

`ifdef DATA_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr_fb(lfsr)};
  end

  assign cd_load_val = CD_W'(DELAY) + CD_W'(lfsr[1:0]);
`else
  assign cd_load_val = CD_W'(DELAY);
`endif

  // Reload whenever a new entry reaches the head of the queue.
  assign cd_load = (empty & accept) | (pop & ((count > CNT_W'(1)) | accept));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  cd <= '0;
    else if (cd_load)             cd <= cd_load_val;
    else if (!empty && cd != '0)  cd <= cd - CD_W'(1);
  end

  assign addr_ok = (count < CNT_W'(DEPTH));
  assign data_ok = ~empty & (cd == '0);
  assign pop     = data_ok;
  assign rdata   = (data_ok && !head.wr) ? head.rdata : 32'h0;

  logic unused_inputs;
  assign unused_inputs = ^{size, addr[31:ADDR_W+2], addr[1:0], full};

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model (honours DATA_SRAM_RAND_DELAY_EN).
module tb_data_sram_resp;

  localparam int unsigned D  = 2;
  localparam int unsigned DP = 4;

  logic        clk;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic        req0, wr0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  wstrb0;
  logic        addr_ok0, data_ok0;

  data_sram_resp #(.ADDR_W(12), .DELAY(D), .DEPTH(DP)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  data_sram_resp #(.ADDR_W(12), .DELAY(0), .DEPTH(DP)) dut0 (
    .clk(clk), .resetn(resetn), .req(req0), .wr(wr0), .size(size), .addr(addr0),
    .wstrb(wstrb0), .wdata(wdata0), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          acc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  exp_t        q[$];
  logic [31:0] mm [4096];
  int          cyc, last_pop;
  int          passed, total;
  int          acc_total, resp_total;
  logic        s_acc, got_resp;
  logic [31:0] got_rdata;
  int          got_lat;
  logic        s_dok0, s_aok0;
  logic [31:0] s_rd0;
  vec_t        tbl [10];

  task automatic tally(input string name, input bit ok, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tally(name, act === exp, longint'(act), longint'(exp));
  endtask

  // One clock cycle: drive, sample mid-cycle, check against the model, advance.
  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    logic exp_aok;
    int   base, lo, hi;
    exp_t e;
    logic [11:0] wi;
    req = r; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2;
    @(negedge clk);
    s_dok0 = data_ok0; s_aok0 = addr_ok0; s_rd0 = rdata0;
    got_resp = 1'b0;
    s_acc = 1'b0;
    if (!resetn) begin
      chk("rst_addr_ok", 32'(addr_ok), 32'd1);
      chk("rst_data_ok", 32'(data_ok), 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      q.delete();
      last_pop = -100;
    end else begin
      exp_aok = (q.size() < DP);
      chk("addr_ok", 32'(addr_ok), 32'(exp_aok));
      if (q.size() == 0) begin
        chk("data_ok_idle", 32'(data_ok), 32'd0);
      end else begin
        base = (q[0].acc > last_pop) ? q[0].acc : last_pop;
        lo = base + D + 1;
`ifdef DATA_SRAM_RAND_DELAY_EN
        hi = base + D + 4;
`else
        hi = lo;
`endif
        if (data_ok === 1'b1) begin
          tally("resp_cycle", cyc >= lo && cyc <= hi, cyc, (cyc < lo) ? lo : hi);
          e = q.pop_front();
          last_pop = cyc;
          chk("rdata", rdata, e.wr ? 32'h0 : e.data);
          got_resp = 1'b1;
          got_rdata = rdata;
          got_lat = cyc - e.acc;
          resp_total++;
        end else begin
          tally("resp_late", cyc < hi, cyc, hi);
        end
      end
      if (data_ok !== 1'b1) chk("rdata_idle", rdata, 32'h0);
      s_acc = r && exp_aok;
      if (s_acc) begin
        wi = a[13:2];
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) mm[wi][8*b +: 8] = d[8*b +: 8];
        end
        e.wr = w;
        e.data = w ? 32'h0 : mm[wi];
        e.acc = cyc;
        q.push_back(e);
        acc_total++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, w, a, s, d);
      if (s_acc) return;
    end
    chk("accept_timeout", 32'(s_acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) return;
      idle();
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_resp(input string name, input logic [31:0] exp_rd);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      idle();
      if (got_resp) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_rdata"}, got_rdata, exp_rd);
`ifdef DATA_SRAM_RAND_DELAY_EN
      tally({name, "_latency"}, got_lat >= D + 1 && got_lat <= D + 4, got_lat, D + 1);
`else
      chk({name, "_latency"}, 32'(got_lat), 32'(D + 1));
`endif
    end
  endtask

  initial begin
    int n_acc, a0, r0;
    logic saw_full;
    logic [31:0] ra;
    passed = 0; total = 0; cyc = 0; last_pop = -100;
    acc_total = 0; resp_total = 0;
    resetn = 1'b0;
    req = 0; wr = 0; size = 2'd2; addr = 0; wstrb = 0; wdata = 0;
    req0 = 0; wr0 = 0; addr0 = 0; wstrb0 = 0; wdata0 = 0;

    tbl[0] = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h20,   4'hF, 32'h11223344, 32'h0};
    tbl[3] = '{1'b1, 32'h20,   4'h2, 32'h0000AA00, 32'h0};
    tbl[4] = '{1'b0, 32'h20,   4'h0, 32'h0,        32'h1122AA44};
    tbl[5] = '{1'b1, 32'h20,   4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[6] = '{1'b0, 32'h23,   4'h0, 32'h0,        32'h1122AA44};
    tbl[7] = '{1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF};
    tbl[8] = '{1'b1, 32'h4010, 4'h8, 32'h55000000, 32'h0};
    tbl[9] = '{1'b0, 32'h10,   4'h0, 32'h0,        32'h55ADBEEF};

    @(posedge clk); #1;
    idle();
    chk("rst_data_ok0", 32'(s_dok0), 32'd0);
    chk("rst_addr_ok0", 32'(s_aok0), 32'd1);
    resetn = 1'b1;
    idle();

    // Give every word used below a known value.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom);
    drain();

    for (int i = 0; i < 10; i++) begin
      drain();
      issue(tbl[i].wr, tbl[i].addr, tbl[i].wstrb, tbl[i].wdata);
      wait_resp($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Request held high for six cycles.
    drain();
    n_acc = 0; saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0);
      if (s_acc) n_acc++;
      else saw_full = 1'b1;
    end
    chk("burst_full_seen", 32'(saw_full), 32'd1);
`ifndef DATA_SRAM_RAND_DELAY_EN
    chk("burst_accepts", 32'(n_acc), 32'd5);
`endif
    drain();

`ifndef DATA_SRAM_RAND_DELAY_EN
    // Zero-delay instance: back-to-back traffic answers on consecutive cycles.
    req0 = 1; wr0 = 1; addr0 = 32'h0; wstrb0 = 4'hF; wdata0 = 32'hA0A0A0A0;
    idle();
    chk("d0_c0_data_ok", 32'(s_dok0), 32'd0);
    chk("d0_c0_addr_ok", 32'(s_aok0), 32'd1);
    addr0 = 32'h4; wdata0 = 32'hB1B1B1B1;
    idle();
    chk("d0_c1_data_ok", 32'(s_dok0), 32'd1);
    chk("d0_c1_rdata", s_rd0, 32'h0);
    wr0 = 0; addr0 = 32'h0;
    idle();
    chk("d0_c2_data_ok", 32'(s_dok0), 32'd1);
    addr0 = 32'h4;
    idle();
    chk("d0_c3_data_ok", 32'(s_dok0), 32'd1);
    chk("d0_c3_rdata", s_rd0, 32'hA0A0A0A0);
    req0 = 0;
    idle();
    chk("d0_c4_data_ok", 32'(s_dok0), 32'd1);
    chk("d0_c4_rdata", s_rd0, 32'hB1B1B1B1);
    idle();
    chk("d0_c5_data_ok", 32'(s_dok0), 32'd0);
`endif

    // Reset with three responses outstanding.
    drain();
    issue(1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    issue(1'b0, 32'h14, 4'h0, 32'h0);
    chk("pre_reset_outstanding", 32'(q.size()), 32'd3);
    resetn = 1'b0;
    idle();
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) idle();
    issue(1'b0, 32'h30, 4'h0, 32'h0);
    wait_resp("post_reset_mem", 32'hCAFEF00D);

    // Randomized traffic against the model.
    drain();
    a0 = acc_total; r0 = resp_total;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      ra[13:6] = 8'h0;
      step($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), ra, 4'($urandom), $urandom);
    end
    drain();
    chk("rand_resp_count", 32'(resp_total - r0), 32'(acc_total - a0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
